dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single synchronous data memory between two requesters: port 0 is the processor load/store path, port 1 is the program/data loader (DMA) port.
- Arbitrates round-robin and registers the winning request. Drives the RAM for exactly one cycle, then returns read data with a valid strobe.
- Sits between the control/datapath and the data memory instance; it replaces the direct MemWrite/dAddress connection to the RAM.

Parameters:
- ADDR_W, 9, RAM address width; the RAM takes byte address bits [ADDR_W-1:0].
- DATA_W, 32, data word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 access request; held high until p0_gnt.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  32  port 0 byte address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  one-cycle pulse: port 0 request accepted and issued to RAM.
- p0_rvalid  out  1  one-cycle pulse: p0_rdata valid (reads only).
- p0_rdata  out  DATA_W  port 0 read data.
- p0_err  out  1  one-cycle pulse, same cycle as p0_gnt: request rejected.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0, for port 1.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_din  out  DATA_W  RAM write data.
- mem_dout  in  DATA_W  RAM read data; valid the cycle after the address is presented.

Behaviour:
- Reset: state IDLE, rr_last=1 so port 0 has priority. All outputs are 0. No RAM write may occur during reset or in the cycle after reset deasserts.
- States:
  - IDLE: waiting for a request.
  - ISSUE: RAM driven from registered owner/we/addr/wdata.
  - RESP: read data returned.
- IDLE -> ISSUE when any req is high at a rising edge.
  - The winner is latched (owner, we, addr, wdata).
  - Winner selection: only one req high -> that port. Both high -> the port != rr_last.
- In ISSUE:
  - gnt[owner]=1 for exactly this cycle.
  - mem_addr = latched addr[ADDR_W-1:0].
  - mem_din = latched wdata.
  - mem_we = latched we AND NOT bad.
  - rr_last <= owner.
- ISSUE -> RESP always.
- In RESP:
  - For an accepted read: rvalid[owner]=1 and rdata[owner]=mem_dout for one cycle.
  - For a write or an error: no rvalid.
  - rdata holds its last value otherwise.
- RESP -> ISSUE directly if any req is high, with a new winner chosen exactly as from IDLE. Otherwise RESP -> IDLE.
  - Peak throughput: one access per 2 cycles.
  - Read latency: gnt at T, rvalid at T+1.
- Requester rule: req must stay high until gnt.
  - The requester drops req in the cycle after gnt, or keeps it high to queue a new access.
  - The arbiter samples req only at decision edges (IDLE or RESP).
  - A req that drops before being sampled is simply lost; no error is raised.
- Bad request: addr[1:0] != 0 (misaligned) or addr[31:ADDR_W] != 0 (out of range).
  - Behaves as granted: gnt and err pulse together in ISSUE.
  - mem_we stays 0 and no rvalid follows.
- mem_we is asserted only in ISSUE; mem_addr/mem_din are 0 in IDLE.
- Both ports request the same address in the same cycle: serialized in round-robin order. No forwarding.
- Reset asserted in ISSUE aborts the access: mem_we drops immediately (async), no rvalid, the requester must re-request.
- Fairness: with both ports requesting continuously, grants strictly alternate, so worst-case wait is 2 accesses (4 cycles).

Decomposition:
- Shared package:
  - state encoding (IDLE=2'b00, ISSUE=2'b01, RESP=2'b10)
  - port index constants PORT_CPU=0, PORT_DMA=1
  - DATA_W / ADDR_W defaults
- One natural sub-module: rr_arbiter2, the 2-way round-robin picker (inputs req[1:0], last; outputs valid, winner). It is combinational, and its pointer register stays in dmem_arbiter.

Test Plan:
- Reset, then p0 write addr=0x10 data=0xDEADBEEF -> p0_gnt one cycle with mem_we=1, mem_addr=0x010. Then p0 read of 0x10 -> p0_rvalid the cycle after p0_gnt with p0_rdata=0xDEADBEEF.
- p0 and p1 both read continuously (0x20 / 0x40) for 8 accesses -> grants alternate p0,p1,p0,...; first grant goes to p0 after reset; one gnt every 2 cycles.
- p1 write addr=0x0000_0202 (misaligned) -> p1_gnt and p1_err same cycle, mem_we stays 0. Follow with p1 write addr=0x0000_0400 (out of range, ADDR_W=9) -> err, RAM contents unchanged on readback.
- p0 write 0x11111111 and p1 write 0x22222222 to 0x30 in the same cycle -> p0 wins (rr_last=1); final read of 0x30 returns 0x22222222.
- rst asserted mid-ISSUE of a p1 write to 0x50 -> mem_we falls asynchronously, all outputs 0. After release, readback of 0x50 returns the pre-test value.
- p0 raises req for one cycle while the arbiter is in ISSUE serving p1 and drops it before RESP -> no p0_gnt, no p0_err, FSM returns to IDLE.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Holds the FSM state encoding, the requester port indices, the default
// bus widths and the helper that classifies a request address as bad.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int DEFAULT_ADDR_W = 9;
    localparam int DEFAULT_DATA_W = 32;

    // A request is rejected when it is not word aligned or when any byte
    // address bit above the RAM's address range is set.
    function automatic logic addr_is_bad(input logic [31:0] addr, input int addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> addr_w) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM.
// Ports:
//   p0_* / p1_*  : requester handshake (req/we/addr/wdata in, gnt/rvalid/rdata/err out)
//   mem_*        : synchronous RAM interface (we/addr/din out, dout in)
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding environment's view (requesters plus RAM)
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              p0_req;
    logic              p0_we;
    logic [31:0]       p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [31:0]       p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_err;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_dout,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_we, mem_addr, mem_din
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_dout,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_we, mem_addr, mem_din
    );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin picker, purely combinational.
// Ports:
//   req[1:0] in  : request lines, index = port number
//   last     in  : port that won the previous arbitration
//   valid    out : at least one request is present
//   winner   out : selected port (meaningful only when valid)
// The "last" pointer is owned by the caller.
module rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    // A lone request always wins; on a tie the port that did not win last
    // time is chosen, which makes back-to-back grants strictly alternate.
    always_comb begin
        valid  = |req;
        winner = PORT_CPU;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[PORT_DMA]) begin
            winner = PORT_DMA;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous RAM between the processor
// load/store port (port 0) and the loader/DMA port (port 1).
// Ports:
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   bus (slave) : both requester handshakes plus the RAM interface
// One access takes an ISSUE cycle (gnt, RAM driven) followed by a RESP
// cycle (read data returned), so peak throughput is one access per two
// cycles and read data appears the cycle after gnt.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    state_t            state;
    logic              owner;
    logic              rd_ok;
    logic              rr_last;
    logic [1:0]        gnt;
    logic [1:0]        err;
    logic [1:0]        rvalid;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_din_r;
    logic [DATA_W-1:0] rdata_hold [2];

    logic              pick_valid;
    logic              pick_winner;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_bad;

    rr_arbiter2 u_pick (
        .req    ({bus.p1_req, bus.p0_req}),
        .last   (rr_last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Route the winning port's request fields so they can be latched at the
    // decision edge together with the bad-address classification.
    always_comb begin
        sel_we    = bus.p0_we;
        sel_addr  = bus.p0_addr;
        sel_wdata = bus.p0_wdata;
        if (pick_winner == PORT_DMA) begin
            sel_we    = bus.p1_we;
            sel_addr  = bus.p1_addr;
            sel_wdata = bus.p1_wdata;
        end
    end

    assign sel_bad = addr_is_bad(sel_addr, ADDR_W);

    // Main FSM. Every handshake and RAM output is a register loaded at the
    // edge that enters the cycle in which it is meant to be seen, so gnt/err
    // and the RAM drive are live exactly during ISSUE and rvalid exactly
    // during RESP. Requests are only looked at from IDLE or RESP; anything
    // raised and dropped while in ISSUE is never seen. The round-robin
    // pointer moves when the access leaves ISSUE. Reset clears mem_we
    // asynchronously, which aborts an in-flight write before the RAM edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= PORT_CPU;
            rd_ok         <= 1'b0;
            rr_last       <= PORT_DMA;
            gnt           <= 2'b00;
            err           <= 2'b00;
            rvalid        <= 2'b00;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_din_r     <= '0;
            rdata_hold[0] <= '0;
            rdata_hold[1] <= '0;
        end else begin
            gnt        <= 2'b00;
            err        <= 2'b00;
            rvalid     <= 2'b00;
            mem_we_r   <= 1'b0;
            mem_addr_r <= '0;
            mem_din_r  <= '0;
            case (state)
                IDLE, RESP: begin
                    if (state == RESP && rvalid[owner]) begin
                        rdata_hold[owner] <= bus.mem_dout;
                    end
                    if (pick_valid) begin
                        state            <= ISSUE;
                        owner            <= pick_winner;
                        rd_ok            <= ~sel_we & ~sel_bad;
                        gnt[pick_winner] <= 1'b1;
                        err[pick_winner] <= sel_bad;
                        mem_we_r         <= sel_we & ~sel_bad;
                        mem_addr_r       <= sel_addr[ADDR_W-1:0];
                        mem_din_r        <= sel_wdata;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    state         <= RESP;
                    rr_last       <= owner;
                    rvalid[owner] <= rd_ok;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read data is taken straight from the RAM during the valid cycle and
    // otherwise shows the last word returned to that port.
    assign bus.p0_gnt    = gnt[0];
    assign bus.p1_gnt    = gnt[1];
    assign bus.p0_err    = err[0];
    assign bus.p1_err    = err[1];
    assign bus.p0_rvalid = rvalid[0];
    assign bus.p1_rvalid = rvalid[1];
    assign bus.p0_rdata  = rvalid[0] ? bus.mem_dout : rdata_hold[0];
    assign bus.p1_rdata  = rvalid[1] ? bus.mem_dout : rdata_hold[1];
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_din   = mem_din_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a synchronous RAM model, a table of
// single-port accesses, hand-written multi-cycle sequences and a randomized
// two-requester run checked against a transaction-level reference model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int WORDS  = (1 << ADDR_W) / 4;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] ram       [WORDS];
    logic [31:0]       model_mem [WORDS];

    vec_t        vecs [10];
    txn_t        txn [2];
    logic        req_on [2];
    logic [31:0] exp_rd [2];
    logic [31:0] last_rd [2];
    logic [1:0]  exp_rv;
    logic        exp_any, exp_w, bad_w, model_last, prev_gnt;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous RAM: write on the edge, read data registered one cycle.
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr[ADDR_W-1:2]] <= bus.mem_din;
        bus.mem_dout <= ram[bus.mem_addr[ADDR_W-1:2]];
    end

    // Hard stop in case something wedges the sequence below.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    function automatic logic model_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= (1 << ADDR_W));
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'((a % (1 << ADDR_W)) / 4);
    endfunction

    function automatic logic gnt_of(input int p);
        return (p == 0) ? bus.p0_gnt : bus.p1_gnt;
    endfunction

    function automatic logic err_of(input int p);
        return (p == 0) ? bus.p0_err : bus.p1_err;
    endfunction

    function automatic logic rvalid_of(input int p);
        return (p == 0) ? bus.p0_rvalid : bus.p1_rvalid;
    endfunction

    function automatic logic [31:0] rdata_of(input int p);
        return (p == 0) ? bus.p0_rdata : bus.p1_rdata;
    endfunction

    function automatic logic outputs_zero();
        return {bus.p0_gnt, bus.p1_gnt, bus.p0_err, bus.p1_err, bus.p0_rvalid,
                bus.p1_rvalid, bus.mem_we} == 7'd0 &&
               bus.mem_addr == '0 && bus.mem_din == '0 &&
               bus.p0_rdata == '0 && bus.p1_rdata == '0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic drive_port(input int p, input logic req, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        drive_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", 32'(outputs_zero()), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_release_we", 32'(bus.mem_we), 32'd0);
    endtask

    task automatic wait_any_gnt(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.p0_gnt || bus.p1_gnt) got = 1'b1;
        end
        checkOutput({name, "_gnt_seen"}, 32'(got), 32'd1);
    endtask

    // One access from one port, held until granted, then dropped. Checks the
    // RAM drive during the grant cycle against the address rules and keeps
    // the reference memory up to date on accepted writes.
    task automatic run_access(input int p, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic err_o,
                              output logic rv_o, output logic [31:0] rd_o);
        bit   got;
        logic bad;
        bad   = model_bad(addr);
        got   = 1'b0;
        err_o = 1'b0;
        rv_o  = 1'b0;
        rd_o  = 32'd0;
        drive_port(p, 1'b1, we, addr, wdata);
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (gnt_of(p)) got = 1'b1;
        end
        checkOutput("acc_gnt_seen", 32'(got), 32'd1);
        drive_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
        if (got) begin
            err_o = err_of(p);
            checkOutput("acc_other_gnt", 32'(gnt_of(1 - p)), 32'd0);
            checkOutput("acc_mem_we", 32'(bus.mem_we), 32'(we && !bad));
            if (!bad) checkOutput("acc_mem_addr", 32'(bus.mem_addr), addr % (1 << ADDR_W));
            if (!bad && we) checkOutput("acc_mem_din", bus.mem_din, wdata);
            @(negedge clk);
            rv_o = rvalid_of(p);
            rd_o = rdata_of(p);
            if (!bad && we) model_mem[word_idx(addr)] = wdata;
        end
    endtask

    task automatic applyStimulus(input int i);
        logic        e, rv;
        logic [31:0] rd;
        run_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, e, rv, rd);
        checkOutput($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
        checkOutput($sformatf("vec%0d_rvalid", i), 32'(rv), 32'(vecs[i].exp_rvalid));
        if (vecs[i].exp_rvalid) checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    endtask

    initial begin
        logic        e, rv;
        logic [31:0] rd, pre;
        int          grants, last_cyc, cyc;
        logic        rv_pending, rv_port;

        for (int i = 0; i < WORDS; i++) begin
            ram[i]       = init_word(i);
            model_mem[i] = init_word(i);
        end
        bus.mem_dout = '0;
        for (int p = 0; p < 2; p++) begin
            txn[p]     = '{1'b0, 32'd0, 32'd0};
            req_on[p]  = 1'b0;
            exp_rd[p]  = 32'd0;
            last_rd[p] = 32'd0;
        end

        vecs[0] = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{1, 1'b1, 32'h0000_0202, 32'hAAAA_0001, 1'b1, 1'b0, 32'h0};
        vecs[3] = '{1, 1'b1, 32'h0000_0400, 32'hAAAA_0002, 1'b1, 1'b0, 32'h0};
        vecs[4] = '{1, 1'b0, 32'h0000_0200, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[5] = '{1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'hC0DE_0000};
        vecs[6] = '{0, 1'b0, 32'h0000_01FC, 32'h0,         1'b0, 1'b1, 32'hC0DE_007F};
        vecs[7] = '{1, 1'b1, 32'h0000_01FC, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
        vecs[8] = '{0, 1'b0, 32'h0000_01FC, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
        vecs[9] = '{0, 1'b0, 32'h0000_0003, 32'h0,         1'b1, 1'b0, 32'h0};

        $display("[TB] reset and single-port table");
        do_reset();
        for (int i = 0; i < 10; i++) applyStimulus(i);

        $display("[TB] continuous reads from both ports");
        do_reset();
        drive_port(0, 1'b1, 1'b0, 32'h20, 32'd0);
        drive_port(1, 1'b1, 1'b0, 32'h40, 32'd0);
        grants = 0; last_cyc = 0; cyc = 0; rv_pending = 1'b0; rv_port = 1'b0;
        for (int i = 0; i < 40 && grants < 8; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.p0_gnt || bus.p1_gnt) begin
                checkOutput($sformatf("alt%0d_p1_gnt", grants), 32'(bus.p1_gnt), 32'(grants % 2));
                checkOutput($sformatf("alt%0d_p0_gnt", grants), 32'(bus.p0_gnt), 32'(1 - grants % 2));
                if (grants > 0) checkOutput("alt_gap", 32'(cyc - last_cyc), 32'd2);
                last_cyc   = cyc;
                rv_port    = 1'(grants % 2);
                rv_pending = 1'b1;
                grants++;
            end else if (rv_pending) begin
                checkOutput("alt_rvalid", 32'(rvalid_of(int'(rv_port))), 32'd1);
                checkOutput("alt_rdata", rdata_of(int'(rv_port)),
                            model_mem[rv_port ? 32'h40 / 4 : 32'h20 / 4]);
                rv_pending = 1'b0;
            end
        end
        checkOutput("alt_count", 32'(grants), 32'd8);
        drive_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] same-cycle writes to one address");
        do_reset();
        drive_port(0, 1'b1, 1'b1, 32'h30, 32'h1111_1111);
        drive_port(1, 1'b1, 1'b1, 32'h30, 32'h2222_2222);
        wait_any_gnt("coll_first");
        checkOutput("coll_first_p0", 32'(bus.p0_gnt), 32'd1);
        checkOutput("coll_first_p1", 32'(bus.p1_gnt), 32'd0);
        checkOutput("coll_first_din", bus.mem_din, 32'h1111_1111);
        drive_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        wait_any_gnt("coll_second");
        checkOutput("coll_second_p1", 32'(bus.p1_gnt), 32'd1);
        checkOutput("coll_second_din", bus.mem_din, 32'h2222_2222);
        drive_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
        model_mem[32'h30 / 4] = 32'h2222_2222;
        @(negedge clk);
        run_access(0, 1'b0, 32'h30, 32'd0, e, rv, rd);
        checkOutput("coll_readback", rd, 32'h2222_2222);

        $display("[TB] reset during a write");
        do_reset();
        pre = model_mem[32'h50 / 4];
        drive_port(1, 1'b1, 1'b1, 32'h50, 32'hBAD0_BAD0);
        wait_any_gnt("abort");
        checkOutput("abort_p1_gnt", 32'(bus.p1_gnt), 32'd1);
        checkOutput("abort_we_before", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_we_async", 32'(bus.mem_we), 32'd0);
        checkOutput("abort_outputs", 32'(outputs_zero()), 32'd1);
        drive_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_post_we", 32'(bus.mem_we), 32'd0);
        checkOutput("abort_post_rvalid", 32'(bus.p1_rvalid), 32'd0);
        run_access(1, 1'b0, 32'h50, 32'd0, e, rv, rd);
        checkOutput("abort_readback", rd, pre);

        $display("[TB] short request while busy");
        drive_port(1, 1'b1, 1'b0, 32'h44, 32'd0);
        wait_any_gnt("lost");
        checkOutput("lost_p1_gnt", 32'(bus.p1_gnt), 32'd1);
        drive_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_port(0, 1'b1, 1'b1, 32'h60, 32'h5555_AAAA);
        @(negedge clk);
        checkOutput("lost_p1_rvalid", 32'(bus.p1_rvalid), 32'd1);
        checkOutput("lost_p1_rdata", bus.p1_rdata, model_mem[32'h44 / 4]);
        drive_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("lost_p0_gnt", 32'(bus.p0_gnt), 32'd0);
            checkOutput("lost_p0_err", 32'(bus.p0_err), 32'd0);
            checkOutput("lost_mem_we", 32'(bus.mem_we), 32'd0);
        end
        checkOutput("lost_idle", 32'(dut.state == IDLE), 32'd1);

        $display("[TB] randomized traffic");
        do_reset();
        model_last = 1'b1;
        prev_gnt   = 1'b0;
        exp_rv     = 2'b00;
        for (int p = 0; p < 2; p++) begin
            req_on[p]  = 1'b0;
            last_rd[p] = 32'd0;
        end
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            exp_any = !prev_gnt && (req_on[0] || req_on[1]);
            exp_w   = (req_on[0] && req_on[1]) ? !model_last : req_on[1];
            bad_w   = model_bad(txn[exp_w].addr);
            checkOutput("rnd_gnt0", 32'(bus.p0_gnt), 32'(exp_any && !exp_w));
            checkOutput("rnd_gnt1", 32'(bus.p1_gnt), 32'(exp_any && exp_w));
            checkOutput("rnd_err0", 32'(bus.p0_err), 32'(exp_any && !exp_w && bad_w));
            checkOutput("rnd_err1", 32'(bus.p1_err), 32'(exp_any && exp_w && bad_w));
            checkOutput("rnd_mem_we", 32'(bus.mem_we), 32'(exp_any && txn[exp_w].we && !bad_w));
            for (int p = 0; p < 2; p++) begin
                checkOutput($sformatf("rnd_rvalid%0d", p), 32'(rvalid_of(p)), 32'(exp_rv[p]));
                if (exp_rv[p]) last_rd[p] = exp_rd[p];
                checkOutput($sformatf("rnd_rdata%0d", p), rdata_of(p), last_rd[p]);
            end
            exp_rv = 2'b00;
            if (exp_any) begin
                if (!bad_w) checkOutput("rnd_mem_addr", 32'(bus.mem_addr),
                                        txn[exp_w].addr % (1 << ADDR_W));
                if (!bad_w && txn[exp_w].we) begin
                    checkOutput("rnd_mem_din", bus.mem_din, txn[exp_w].wdata);
                    model_mem[word_idx(txn[exp_w].addr)] = txn[exp_w].wdata;
                end
                if (!bad_w && !txn[exp_w].we) begin
                    exp_rv[exp_w] = 1'b1;
                    exp_rd[exp_w] = model_mem[word_idx(txn[exp_w].addr)];
                end
                model_last     = exp_w;
                req_on[exp_w]  = 1'b0;
            end
            prev_gnt = exp_any;
            for (int p = 0; p < 2; p++) begin
                if (!req_on[p] && $urandom_range(0, 99) < 55) begin
                    int r;
                    r = int'($urandom_range(0, 9));
                    txn[p].we    = 1'($urandom_range(0, 1));
                    txn[p].wdata = $urandom;
                    if (r == 0)
                        txn[p].addr = 32'($urandom_range(0, 127) * 4 + $urandom_range(1, 3));
                    else if (r == 1)
                        txn[p].addr = 32'(($urandom_range(1, 1000) << ADDR_W) + $urandom_range(0, 127) * 4);
                    else
                        txn[p].addr = 32'($urandom_range(0, 31) * 4);
                    req_on[p] = 1'b1;
                end
                drive_port(p, req_on[p], txn[p].we, txn[p].addr, txn[p].wdata);
            end
        end
        drive_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
